// File: rtl/sser_pkg.sv
// Shared types and defaults for the SSER serial-ID byte collector.
// Exports: acc_t bus qualifier, col_state_e, SYNC_NIB_D, TIMEOUT_D.
package sser_pkg;

  localparam logic [3:0] SYNC_NIB_D = 4'hF;
  localparam int         TIMEOUT_D  = 255;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } col_state_e;

  function automatic logic acc_t(
    input logic sser,
    input logic ba13,
    input logic ba12,
    input logic br_w
  );
    return ~sser & ~ba13 & ba12 & br_w;
  endfunction

endpackage

// File: rtl/sdrd_byte_collector_if.sv
// Read-side handshake bundle between the collector FIFO and the host.
// master: rd_data/rd_valid out, rd_ready in; slave: the reverse.
interface sdrd_byte_collector_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/sdrd_fifo.sv
// WIDTH x DEPTH synchronous FIFO with a registered head word.
// Ports: push/wdata in, pop in, rdata head out, full/empty flags out.
module sdrd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head_q;
  logic             wr;
  logic             rd;
  logic [AW-1:0]    rptr_nx;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign rd      = pop & ~empty;
  assign wr      = push & (~full | rd);
  assign rptr_nx = rptr + AW'(1);
  assign rdata   = head_q;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr_nx;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head word is a register: it loads straight from wdata when the
  // write lands on an empty (or emptying) FIFO, otherwise from memory.
  // With nothing left it keeps the last word handed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (wr && (empty || (rd && cnt == CW'(1)))) begin
      head_q <= wdata;
    end else if (rd && cnt > CW'(1)) begin
      head_q <= mem[rptr_nx];
    end
  end

endmodule

// File: rtl/sdrd_byte_collector.sv
// Captures one SDRD bit per qualified SSER access, LSB-first, into words.
// Ports: bus qualifiers + SDRD in, rd handshake, sticky flags, bit_cnt.
module sdrd_byte_collector
  import sser_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         DEPTH    = 2,
  parameter logic [3:0] SYNC_NIB = SYNC_NIB_D,
  parameter int         TIMEOUT  = TIMEOUT_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SSER,
  input  logic                   BA13,
  input  logic                   BA12,
  input  logic [3:0]             BA,
  input  logic                   BR_W,
  input  logic                   SDRD,
  sdrd_byte_collector_if.master  rd,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   flag_clr,
  output logic [$clog2(WIDTH):0] bit_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  col_state_e       state;
  logic             acc;
  logic             acc_q;
  logic             ev;
  logic             sync_ev;
  logic             dat_ev;
  logic             word_done;
  logic             tmo_fire;
  logic [TW-1:0]    tmo_cnt;
  // Only WIDTH-1 bits are ever parked here; the last bit goes
  // straight into the pushed word.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-2:0] sr_nx;
  logic [WIDTH-1:0] word;
  logic             f_full;
  logic             f_empty;
  logic             pop;
  logic             push;
  logic             ovr_set;

  assign acc     = acc_t(SSER, BA13, BA12, BR_W);
  assign ev      = acc & ~acc_q;
  assign sync_ev = ev & (BA == SYNC_NIB);
  assign dat_ev  = ev & (BA != SYNC_NIB);

  assign word_done = dat_ev & (bit_cnt == CW'(WIDTH - 1));
  assign tmo_fire  = (state == ST_SHIFT) & ~ev
                   & (tmo_cnt == TW'(TIMEOUT - 1));

  assign word = {SDRD, sr};

  always_comb begin
    sr_nx            = sr >> 1;
    sr_nx[WIDTH-2]   = SDRD;
  end

  assign pop     = ~f_empty & rd.rd_ready;
  assign push    = word_done;
  assign ovr_set = word_done & f_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= 1'b0;
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      acc_q <= acc;
      if (sync_ev || tmo_fire) begin
        state   <= ST_IDLE;
        sr      <= '0;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (dat_ev) begin
        tmo_cnt <= '0;
        if (word_done) begin
          state   <= ST_IDLE;
          sr      <= '0;
          bit_cnt <= '0;
        end else begin
          state   <= ST_SHIFT;
          sr      <= sr_nx;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (state == ST_SHIFT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // A new set in the same cycle as flag_clr keeps the flag up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)       overrun <= 1'b1;
      else if (flag_clr) overrun <= 1'b0;
      if (tmo_fire)      frame_err <= 1'b1;
      else if (flag_clr) frame_err <= 1'b0;
    end
  end

  logic [WIDTH-1:0] f_rdata;

  sdrd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign rd.rd_data  = f_rdata;
  assign rd.rd_valid = ~f_empty;

endmodule

// File: doc/sdrd_byte_collector.md
# sdrd_byte_collector

Downstream stage of the SSER serial-ID sequencer GAL. It watches the same qualified bus window (SSER low, BA13 low, BA12 high, BR_W high) and captures one SDRD bit per bus access. Bits are assembled LSB-first into bytes, which are queued in a small FIFO for the host-side register file. Partial bytes are discarded on a sync access or a timeout, and the block flags overruns and framing errors.

## Interface
- `WIDTH`, 8, bits per assembled word.
- `DEPTH`, 2, FIFO entries; must be a power of two, at least 2.
- `SYNC_NIB`, 4'hF, BA[7:4] value that marks a sync access.
- `TIMEOUT`, 255, idle clk cycles allowed between bits of one word before the partial word is dropped.
- `clk`  in  1  the one clock; all inputs are synchronous to it.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `SSER`  in  1  serial select, active low.
- `BA13`, `BA12`  in  1 each  bus address bits.
- `BA`  in  4  bus address bits BA[7:4].
- `BR_W`  in  1  bus read/write, high = read.
- `SDRD`  in  1  serial data bit driven by the sequencer GAL.
- `rd_data`  out  WIDTH  FIFO head word.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer pop; a word pops on a clk edge where `rd_valid` and `rd_ready` are both high.
- `overrun`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a partial word was dropped on timeout.
- `flag_clr`  in  1  clears `overrun` and `frame_err`.
- `bit_cnt`  out  clog2(WIDTH)+1  bits held in the partial word.

## Operation
- `acc` = ~SSER & ~BA13 & BA12 & BR_W. `acc_q` is `acc` registered.
- An access event (`ev`) occurs in a cycle where `acc` is high and `acc_q` is low. There is exactly one event per access, however long the access lasts.
- Sync event: `ev` with BA == SYNC_NIB.
  - Clears the shift register and `bit_cnt`.
  - Stops the timeout counter.
  - Does not store SDRD.
  - Goes to IDLE.
- Data event: `ev` with BA != SYNC_NIB.
  - Shifts SDRD in: `sr <= {SDRD, sr[WIDTH-1:1]}`, so the first bit ends up in bit 0.
  - Increments `bit_cnt` and resets the timeout counter.
- State machine:
  - IDLE: `bit_cnt` = 0. A data event goes to SHIFT.
  - SHIFT: the timeout counter increments every cycle with no event. When it reaches TIMEOUT, the partial word is discarded, `frame_err` is set, and the state returns to IDLE.
  - Word completion: on the WIDTH-th data event the completed word (including the bit shifted in that cycle) is pushed to the FIFO. `bit_cnt` returns to 0 and the state goes to IDLE.
- FIFO:
  - Push when a word completes and the FIFO is not full.
  - If the FIFO is full and no pop happens in that cycle, the word is dropped and `overrun` is set.
  - If a push and a pop happen in the same cycle when the FIFO is full, the push is accepted and there is no overrun.
  - When the FIFO is empty, `rd_data` holds the last value read (0 after reset).
- Flags: if a set and `flag_clr` occur in the same cycle, the set wins.

## Timing
- Reset values:
  - `rd_data`, `rd_valid`, `overrun`, `frame_err`, `bit_cnt` all 0.
  - FIFO empty, state IDLE, `acc_q` 0, timeout counter 0.
- `rst_n` low clears everything immediately, including mid-word and mid-access.
  - If `acc` is still high after reset deasserts, that access produces an event on the first edge, because `acc_q` is 0.
- Latency: SDRD is sampled at the edge that ends the `ev` cycle. `rd_valid` rises one cycle after the completing event.
- `bit_cnt` updates at the same edge as the event that changes it.
- Timeout fires at the edge where the idle count equals TIMEOUT, i.e. TIMEOUT cycles after the last data event.
- Simultaneous data event and timeout: the event wins, and the counter resets.
- Pop: `rd_data` moves to the next entry at the pop edge. `rd_valid` drops at that edge if the FIFO becomes empty.

## Structure
- Package `sser_pkg`:
  - `acc_t` qualifier function.
  - Collector state enum {IDLE, SHIFT}.
  - Default constants: SYNC_NIB, TIMEOUT.
- Sub-module `sdrd_fifo`: parameterised WIDTH × DEPTH synchronous FIFO with full/empty flags, async active-low reset, and bypass-free registered output.
- Top level holds edge detect, shift register, FSM, timeout counter and flags. Estimated 200–300 lines.

## Test plan
- Eight data events (BA=4'h0, SDRD=1,0,1,1,0,0,1,0) → `rd_data`=8'h4D and `rd_valid`=1 one cycle after the 8th event; flags stay 0.
- Three data events, then a sync access (BA=4'hF), then eight bits of 8'hA5 → only 8'hA5 is queued and `bit_cnt` reads 0 after the sync.
- Hold `acc` high for 10 cycles → one event, and `bit_cnt` increments by exactly 1.
- Four bits, then idle for 255 cycles → `frame_err`=1, `bit_cnt`=0, nothing queued; `flag_clr` → `frame_err`=0.
- `rd_ready`=0, push 3 words with DEPTH=2 → the first two are held and `overrun`=1. Repeat with `rd_ready`=1 in the third word's completion cycle → no overrun and the third word is queued.
- Assert `rst_n` low mid-word with `acc` high → all outputs 0. After release, the held access produces one event.
